data_mem_responder: RTL and testbench

- Responder end of the MEM-stage data-memory interface: accepts one read or write request at a time from the pipeline and completes it after a configurable number of wait states.
- Holds the pipeline with a stall signal until the access completes.
- Owns the word-addressed data storage.
- Replaces the single-cycle data memory so that stall and hazard logic can be exercised against realistic memory latency.

---
 rtl/data_mem_responder_pkg.sv | 34 +++
 rtl/data_mem_responder_array.sv | 32 +++
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// datapath widths, the base address of the data region, the FSM
// state encoding and a helper for the wait-state counter load value.
package data_mem_responder_pkg;

  // Datapath widths used across the pipeline.
  localparam int WORD_LEN    = 32;
  localparam int ADDRESS_LEN = 32;

  // Byte address that maps to word 0 of the data storage.
  localparam int DMEM_BASE_ADDR = 1024;

  // Wait-state counter width; covers WAIT_CYCLES in 0..15.
  localparam int WAIT_CNT_W = 4;

  // Responder FSM states. The numeric values are kept stable so that
  // waveforms and any debug tooling keep reading the same codes.
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  // Value loaded into the wait-state counter on entering BUSY. With no
  // wait states BUSY is never entered, so the value is irrelevant and 0
  // is returned to keep the counter quiet.
  function automatic logic [WAIT_CNT_W-1:0] waitLoadValue(input int waitCycles);
    if (waitCycles > 0) begin
      return WAIT_CNT_W'(waitCycles - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-addressed data storage behind the responder: one synchronous
// write port and one asynchronous read port. The storage has no reset,
// so its contents survive a pipeline reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_windex,
  input  logic [WORD_LEN-1:0]   i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_rindex,
  output logic [WORD_LEN-1:0]   o_rword
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_LEN-1:0] r_mem [0:DEPTH-1];

  // Commit a store to the addressed word on the rising edge.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_windex] <= i_wdata;
    end
  end

  // Loads see the stored word combinationally so the DONE cycle can
  // present it without another pipeline stage.
  assign o_rword = r_mem[i_rindex];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface. Accepts one load
// or store at a time, holds the pipeline with mem_stall while it inserts
// WAIT_CYCLES wait states, then reports completion for exactly one cycle
// (DONE) with the load data or an address-error strobe.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int                     WAIT_CYCLES = 2,
  parameter int                     DEPTH_LOG2  = 6,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR   = ADDRESS_LEN'(DMEM_BASE_ADDR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_read,
  input  logic                   req_write,
  input  logic [ADDRESS_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0]    req_wdata,
  output logic                   mem_stall,
  output logic [WORD_LEN-1:0]    rdata,
  output logic                   rdata_valid,
  output logic                   addr_error
);

  // Number of words in the storage, widened to address width so the
  // range check compares like with like.
  localparam logic [ADDRESS_LEN-1:0] DEPTH_WORDS = ADDRESS_LEN'(1) << DEPTH_LOG2;

  // Counter value on entering BUSY and a width-matched decrement step.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = waitLoadValue(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  // With no wait states the request goes straight from IDLE to DONE and
  // a store must commit on that same edge from the live request inputs.
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_e r_state;
  dmem_state_e w_nextState;

  logic [WAIT_CNT_W-1:0]  r_count;
  logic [DEPTH_LOG2-1:0]  r_index;
  logic [WORD_LEN-1:0]    r_wdata;
  logic                   r_isRead;
  logic                   r_isWrite;
  logic                   r_illegal;

  logic                   w_reqPresent;
  logic                   w_reqIllegal;
  logic [ADDRESS_LEN-1:0] w_offset;
  logic [ADDRESS_LEN-1:0] w_reqIndexWide;
  logic [DEPTH_LOG2-1:0]  w_reqIndex;
  logic                   w_accept;

  logic                   w_commitFromBusy;
  logic                   w_commitFromIdle;
  logic                   w_commit;
  logic [DEPTH_LOG2-1:0]  w_commitIndex;
  logic [WORD_LEN-1:0]    w_commitData;
  logic [WORD_LEN-1:0]    w_rword;

  assign w_reqPresent = req_read | req_write;
  assign w_accept     = (r_state == DMEM_IDLE) && w_reqPresent;

  // Decode the incoming byte address into a word index and decide
  // whether the request may touch storage. The index is kept at full
  // address width for the range test so an address far beyond the
  // storage cannot alias back into it through truncation.
  always_comb begin
    w_offset       = req_addr - BASE_ADDR;
    w_reqIndexWide = w_offset >> 2;
    w_reqIndex     = w_reqIndexWide[DEPTH_LOG2-1:0];
    w_reqIllegal   = (req_addr[1:0] != 2'b00)
                  || (req_addr < BASE_ADDR)
                  || (w_reqIndexWide >= DEPTH_WORDS)
                  || (req_read && req_write);
  end

  // State register; reset always returns the responder to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= DMEM_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. Outputs are forced low while reset is
  // asserted so the pipeline is never held or strobed during reset.
  always_comb begin
    w_nextState = r_state;
    mem_stall   = 1'b0;
    rdata       = '0;
    rdata_valid = 1'b0;
    addr_error  = 1'b0;

    case (r_state)
      DMEM_IDLE: begin
        if (w_reqPresent) begin
          mem_stall = 1'b1;
          if (NO_WAIT) begin
            w_nextState = DMEM_DONE;
          end else begin
            w_nextState = DMEM_BUSY;
          end
        end
      end
      DMEM_BUSY: begin
        mem_stall = 1'b1;
        if (r_count == '0) begin
          w_nextState = DMEM_DONE;
        end
      end
      DMEM_DONE: begin
        w_nextState = DMEM_IDLE;
        addr_error  = r_illegal;
        if (r_isRead && !r_illegal) begin
          rdata_valid = 1'b1;
          rdata       = w_rword;
        end
      end
      default: begin
        w_nextState = DMEM_IDLE;
      end
    endcase

    if (!rst) begin
      mem_stall   = 1'b0;
      rdata       = '0;
      rdata_valid = 1'b0;
      addr_error  = 1'b0;
    end
  end

  // Capture the request on acceptance and run the wait-state counter.
  // Only the captured copy is used afterwards, so the pipeline changing
  // its request lines mid-access has no effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count   <= '0;
      r_index   <= '0;
      r_wdata   <= '0;
      r_isRead  <= 1'b0;
      r_isWrite <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_count   <= WAIT_LOAD;
      r_index   <= w_reqIndex;
      r_wdata   <= req_wdata;
      r_isRead  <= req_read;
      r_isWrite <= req_write;
      r_illegal <= w_reqIllegal;
    end else if ((r_state == DMEM_BUSY) && (r_count != '0)) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  // A legal store commits on the edge that enters DONE. Gating with rst
  // aborts a store whose commit edge coincides with reset.
  assign w_commitFromBusy = (r_state == DMEM_BUSY) && (r_count == '0)
                         && r_isWrite && !r_illegal;
  assign w_commitFromIdle = NO_WAIT && w_accept && req_write && !w_reqIllegal;
  assign w_commit         = rst && (w_commitFromBusy || w_commitFromIdle);
  assign w_commitIndex    = w_commitFromIdle ? w_reqIndex : r_index;
  assign w_commitData     = w_commitFromIdle ? req_wdata  : r_wdata;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clk    (clk),
    .i_we     (w_commit),
    .i_windex (w_commitIndex),
    .i_wdata  (w_commitData),
    .i_rindex (r_index),
    .o_rword  (w_rword)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Two responders share the
// clock and reset: unit 0 has two wait states, unit 1 has none. Expected
// results come from fixed vectors and from a transaction-level memory
// model that applies the address rules with plain arithmetic.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int BASE  = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       reqRead;
  logic [1:0]       reqWrite;
  logic [1:0][31:0] reqAddr;
  logic [1:0][31:0] reqWdata;
  logic [1:0]       memStall;
  logic [1:0][31:0] rdata;
  logic [1:0]       rdataValid;
  logic [1:0]       addrError;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] model [2][DEPTH];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          expErr;
    bit          expValid;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[$];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  data_mem_responder #(
    .WAIT_CYCLES (2),
    .DEPTH_LOG2  (6),
    .BASE_ADDR   (32'd1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (reqRead[0]),
    .req_write   (reqWrite[0]),
    .req_addr    (reqAddr[0]),
    .req_wdata   (reqWdata[0]),
    .mem_stall   (memStall[0]),
    .rdata       (rdata[0]),
    .rdata_valid (rdataValid[0]),
    .addr_error  (addrError[0])
  );

  data_mem_responder #(
    .WAIT_CYCLES (0),
    .DEPTH_LOG2  (6),
    .BASE_ADDR   (32'd1024)
  ) dut0 (
    .clk         (clk),
    .rst         (rst),
    .req_read    (reqRead[1]),
    .req_write   (reqWrite[1]),
    .req_addr    (reqAddr[1]),
    .req_wdata   (reqWdata[1]),
    .mem_stall   (memStall[1]),
    .rdata       (rdata[1]),
    .rdata_valid (rdataValid[1]),
    .addr_error  (addrError[1])
  );

  function automatic int waitOf(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // Address rules stated directly: aligned, at or above the base, inside
  // the storage, and not both load and store at once.
  function automatic bit modelIllegal(input bit rd, input bit wr, input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    if (a % 4 != 0) return 1'b1;
    if (a < BASE) return 1'b1;
    if ((a - BASE) / 4 >= DEPTH) return 1'b1;
    return rd && wr;
  endfunction

  function automatic int modelIndex(input logic [31:0] addr);
    return (int'(addr) - BASE) / 4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request and follow it to completion: count the stalled
  // cycles, note any strobe seen while stalled, and capture the outputs
  // of the first non-stalled cycle. Optionally disturb the request lines
  // once the responder is busy.
  task automatic applyStimulus(input int u, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit alterMidway,
                               output int stallCycles, output logic [31:0] gotRdata,
                               output bit gotValid, output bit gotErr,
                               output bit strobeEarly, output bit timedOut);
    @(negedge clk);
    reqRead[u]  = rd;
    reqWrite[u] = wr;
    reqAddr[u]  = addr;
    reqWdata[u] = wdata;
    stallCycles = 0;
    strobeEarly = 1'b0;
    timedOut    = 1'b1;
    gotRdata    = '0;
    gotValid    = 1'b0;
    gotErr      = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (memStall[u]) begin
        stallCycles++;
        if (rdataValid[u] || addrError[u] || (rdata[u] != 32'd0)) strobeEarly = 1'b1;
        if (alterMidway && stallCycles == 2) begin
          reqAddr[u]  = addr + 32'd8;
          reqWdata[u] = ~wdata;
        end
      end else begin
        gotRdata = rdata[u];
        gotValid = rdataValid[u];
        gotErr   = addrError[u];
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
    end
    reqRead[u]  = 1'b0;
    reqWrite[u] = 1'b0;
    reqAddr[u]  = '0;
    reqWdata[u] = '0;
  endtask

  // Run one request and compare it against the expected completion.
  // Load data is only judged for loads and illegal requests.
  task automatic runAndCheck(input string name, input int u, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wdata, input bit alter,
                             input bit expErr, input bit expValid, input logic [31:0] expRdata);
    int          stallCycles;
    logic [31:0] gotRdata;
    bit          gotValid, gotErr, strobeEarly, timedOut;
    applyStimulus(u, rd, wr, addr, wdata, alter, stallCycles, gotRdata, gotValid, gotErr,
                  strobeEarly, timedOut);
    checkOutput({name, "/timeout"}, 32'(timedOut), 32'd0);
    checkOutput({name, "/stallCycles"}, stallCycles, waitOf(u) + 1);
    checkOutput({name, "/strobeWhileStalled"}, 32'(strobeEarly), 32'd0);
    checkOutput({name, "/rdataValid"}, 32'(gotValid), 32'(expValid));
    checkOutput({name, "/addrError"}, 32'(gotErr), 32'(expErr));
    if (expErr || expValid) checkOutput({name, "/rdata"}, gotRdata, expRdata);
  endtask

  // Model-driven request: expected outcome from the model, which is then
  // updated for a legal store.
  task automatic runModelTxn(input string name, input int u, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
    bit          ill;
    logic [31:0] exp;
    ill = modelIllegal(rd, wr, addr);
    exp = (!ill && rd) ? model[u][modelIndex(addr)] : 32'd0;
    runAndCheck(name, u, rd, wr, addr, wdata, 1'b0, ill, !ill && rd, exp);
    if (!ill && wr) model[u][modelIndex(addr)] = wdata;
  endtask

  // Watchdog so a stuck responder can never hang the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    logic [31:0] a;
    int          sel, op;

    rst      = 1'b0;
    reqRead  = 2'b11;
    reqWrite = 2'b00;
    reqAddr  = {32'd1024, 32'd1024};
    reqWdata = '0;

    // Reset held with a request pending: no stall, no strobes.
    repeat (2) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset%0d/stallDuringReset", u), 32'(memStall[u]), 32'd0);
      checkOutput($sformatf("reset%0d/rdataDuringReset", u), rdata[u], 32'd0);
    end
    reqRead = 2'b00;
    reqAddr = '0;
    rst     = 1'b1;
    @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset%0d/stall", u), 32'(memStall[u]), 32'd0);
      checkOutput($sformatf("reset%0d/rdata", u), rdata[u], 32'd0);
      checkOutput($sformatf("reset%0d/rdataValid", u), 32'(rdataValid[u]), 32'd0);
      checkOutput($sformatf("reset%0d/addrError", u), 32'(addrError[u]), 32'd0);
    end

    // Fill both storages with known contents through the interface.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < DEPTH; i++) begin
        model[u][i] = $urandom;
        runAndCheck($sformatf("init%0d[%0d]", u, i), u, 1'b0, 1'b1, 32'(BASE + 4 * i),
                    model[u][i], 1'b0, 1'b0, 1'b0, 32'd0);
      end
    end

    // Fixed vectors on the two-wait-state unit. Address 1000 would decode
    // to word 58 (1256) and 1280 to word 0 (1024) if range checks were
    // lost, so both are re-read after the illegal stores.
    vecs.push_back('{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'd0,        1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b1, 32'd1256, 32'h11111111, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 32'd1026, 32'd0,        1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 32'd1000, 32'h22222222, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 32'd1280, 32'h33333333, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b1, 1'b1, 32'd1024, 32'h44444444, 1'b1, 1'b0, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'd0,        1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 32'd1256, 32'd0,        1'b0, 1'b1, 32'h11111111});
    vecs.push_back('{1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 32'd1276, 32'd0,        1'b0, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 1'b0, 32'd1280, 32'd0,        1'b1, 1'b0, 32'd0});
    for (int i = 0; i < vecs.size(); i++) begin
      runAndCheck($sformatf("vec[%0d]", i), 0, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                  vecs[i].wdata, 1'b0, vecs[i].expErr, vecs[i].expValid, vecs[i].expRdata);
      if (!vecs[i].expErr && vecs[i].wr) model[0][modelIndex(vecs[i].addr)] = vecs[i].wdata;
    end

    // No-wait unit: back-to-back loads of 1028 and 1032 holding 5 and 7,
    // with the second request already on the lines in the DONE cycle.
    runModelTxn("bb/preload5", 1, 1'b0, 1'b1, 32'd1028, 32'd5);
    runModelTxn("bb/preload7", 1, 1'b0, 1'b1, 32'd1032, 32'd7);
    @(negedge clk);
    reqRead[1] = 1'b1;
    reqAddr[1] = 32'd1028;
    #1;
    checkOutput("bb/c0/stall", 32'(memStall[1]), 32'd1);
    checkOutput("bb/c0/valid", 32'(rdataValid[1]), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("bb/c1/stall", 32'(memStall[1]), 32'd0);
    checkOutput("bb/c1/valid", 32'(rdataValid[1]), 32'd1);
    checkOutput("bb/c1/rdata", rdata[1], 32'd5);
    reqAddr[1] = 32'd1032;
    @(negedge clk);
    #1;
    checkOutput("bb/c2/stall", 32'(memStall[1]), 32'd1);
    checkOutput("bb/c2/valid", 32'(rdataValid[1]), 32'd0);
    checkOutput("bb/c2/rdata", rdata[1], 32'd0);
    @(negedge clk);
    #1;
    checkOutput("bb/c3/stall", 32'(memStall[1]), 32'd0);
    checkOutput("bb/c3/valid", 32'(rdataValid[1]), 32'd1);
    checkOutput("bb/c3/rdata", rdata[1], 32'd7);
    reqRead[1] = 1'b0;
    reqAddr[1] = '0;

    // Request lines changed while busy: the store must use the captured
    // address and data, leaving the word at the altered address alone.
    runModelTxn("alter/preload1048", 0, 1'b0, 1'b1, 32'd1048, 32'h48484848);
    runAndCheck("alter/write1040", 0, 1'b0, 1'b1, 32'd1040, 32'h12345678, 1'b1,
                1'b0, 1'b0, 32'd0);
    model[0][modelIndex(32'd1040)] = 32'h12345678;
    runAndCheck("alter/read1040", 0, 1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 1'b0, 1'b1, 32'h12345678);
    runAndCheck("alter/read1048", 0, 1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 1'b0, 1'b1, 32'h48484848);

    // Reset while a store is busy: the store is aborted and the old word
    // survives; outputs are quiet while reset is held.
    runModelTxn("rstSeq/preload9", 0, 1'b0, 1'b1, 32'd1044, 32'd9);
    @(negedge clk);
    reqWrite[0] = 1'b1;
    reqAddr[0]  = 32'd1044;
    reqWdata[0] = 32'd11;
    #1;
    checkOutput("rstSeq/stallAccept", 32'(memStall[0]), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("rstSeq/stallBusy", 32'(memStall[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstSeq/stall", 32'(memStall[0]), 32'd0);
    checkOutput("rstSeq/rdata", rdata[0], 32'd0);
    checkOutput("rstSeq/rdataValid", 32'(rdataValid[0]), 32'd0);
    checkOutput("rstSeq/addrError", 32'(addrError[0]), 32'd0);
    rst         = 1'b1;
    reqWrite[0] = 1'b0;
    reqAddr[0]  = '0;
    reqWdata[0] = '0;
    runAndCheck("rstSeq/read1044", 0, 1'b1, 1'b0, 32'd1044, 32'd0, 1'b0, 1'b0, 1'b1, 32'd9);

    // Ten idle cycles: nothing stalls or strobes.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("idle[%0d]/stall", c), 32'(memStall[0]), 32'd0);
      checkOutput($sformatf("idle[%0d]/rdataValid", c), 32'(rdataValid[0]), 32'd0);
      checkOutput($sformatf("idle[%0d]/addrError", c), 32'(addrError[0]), 32'd0);
    end

    // Randomised traffic on both units, checked against the model.
    for (int u = 0; u < 2; u++) begin
      for (int t = 0; t < 150; t++) begin
        sel = $urandom_range(0, 9);
        if (sel < 6)       a = 32'(BASE + 4 * $urandom_range(0, DEPTH - 1));
        else if (sel == 6) a = 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        else if (sel == 7) a = 32'($urandom_range(0, BASE - 1));
        else if (sel == 8) a = 32'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000));
        else               a = $urandom;
        op = $urandom_range(0, 9);
        runModelTxn($sformatf("rand%0d[%0d]", u, t), u, (op < 4) || (op == 9),
                    (op >= 4), a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
